// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous-read memory between two
// clients. At most one transaction is granted per cycle, read data returns to
// the issuing client one cycle after its grant, and a client may lock the port
// for back-to-back bursts.
//
// Handshake: a client raises cX_req together with its command and holds both
// stable until cX_gnt=1 in the same cycle; that cycle is the transfer. A read
// granted in cycle N returns with cX_rvalid=1 and cX_rdata in cycle N+1, with
// no back-pressure on the return path.
module mem_port_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 32,
  parameter int PRIO_RR  = 1,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c0_req,
  input  logic          c1_req,
  input  logic          c0_we,
  input  logic          c1_we,
  input  logic          c0_lock,
  input  logic          c1_lock,
  input  logic [AW-1:0] c0_addr,
  input  logic [AW-1:0] c1_addr,
  input  logic [DW-1:0] c0_wdata,
  input  logic [DW-1:0] c1_wdata,
  output logic          c0_gnt,
  output logic          c1_gnt,
  output logic          c0_rvalid,
  output logic          c1_rvalid,
  output logic [DW-1:0] c0_rdata,
  output logic [DW-1:0] c1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_en,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic [1:0]    owner_dbg
);

  typedef enum logic [1:0] {
    FREE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_t;

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  owner_t     owner;
  logic       last_gnt;   // 1 = client 1 was granted most recently
  logic [3:0] wait0;
  logic [3:0] wait1;
  logic       rv0_q;
  logic       rv1_q;

  // Grant decision: ownership first, then single requester, then tie-break.
  always_comb begin
    c0_gnt = 1'b0;
    c1_gnt = 1'b0;
    if (reset) begin
      c0_gnt = 1'b0;
      c1_gnt = 1'b0;
    end else if (owner == OWN0 && c0_req) begin
      c0_gnt = 1'b1;
    end else if (owner == OWN1 && c1_req) begin
      c1_gnt = 1'b1;
    end else if (c0_req && c1_req) begin
      // An owner that dropped req falls through here and loses ownership.
      if (PRIO_RR != 0) begin
        if (last_gnt) c0_gnt = 1'b1;
        else          c1_gnt = 1'b1;
      end else if (wait1 >= WAIT_LIMIT) begin
        c1_gnt = 1'b1;
      end else begin
        c0_gnt = 1'b1;
      end
    end else if (c0_req) begin
      c0_gnt = 1'b1;
    end else if (c1_req) begin
      c1_gnt = 1'b1;
    end
  end

  // Memory command mux: winner's command, all zeros when idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (c0_gnt) begin
      mem_en    = 1'b1;
      mem_we    = c0_we;
      mem_addr  = c0_addr;
      mem_wdata = c0_wdata;
    end else if (c1_gnt) begin
      mem_en    = 1'b1;
      mem_we    = c1_we;
      mem_addr  = c1_addr;
      mem_wdata = c1_wdata;
    end
  end

  // Ownership FSM plus arbitration history and registered read-return flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner    <= FREE;
      last_gnt <= 1'b1;
      wait0    <= 4'd0;
      wait1    <= 4'd0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
    end else begin
      if (c0_gnt && c0_lock)      owner <= OWN0;
      else if (c1_gnt && c1_lock) owner <= OWN1;
      else                        owner <= FREE;

      if (c0_gnt)      last_gnt <= 1'b0;
      else if (c1_gnt) last_gnt <= 1'b1;

      if (c0_req && !c0_gnt) wait0 <= (wait0 == 4'd15) ? 4'd15 : wait0 + 4'd1;
      else                   wait0 <= 4'd0;
      if (c1_req && !c1_gnt) wait1 <= (wait1 == 4'd15) ? 4'd15 : wait1 + 4'd1;
      else                   wait1 <= 4'd0;

      rv0_q <= c0_gnt && !c0_we;
      rv1_q <= c1_gnt && !c1_we;
    end
  end

  // Read data is shared; rvalid tells each client when it is theirs.
  assign c0_rdata  = mem_rdata;
  assign c1_rdata  = mem_rdata;
  assign c0_rvalid = rv0_q;
  assign c1_rvalid = rv1_q;
  assign busy      = mem_en | rv0_q | rv1_q;
  assign owner_dbg = owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one round-robin instance and one fixed-priority
// instance (MAX_WAIT=3) driven by the same directed stimulus, each checked
// every cycle against a rule-level model, plus literal expectations.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        c0_req, c1_req, c0_we, c1_we, c0_lock, c1_lock;
  logic [15:0] c0_addr, c1_addr;
  logic [31:0] c0_wdata, c1_wdata;

  // Index 0 = round-robin instance, index 1 = fixed-priority instance.
  logic        g0 [2];
  logic        g1 [2];
  logic        rv0 [2];
  logic        rv1 [2];
  logic [31:0] rd0 [2];
  logic [31:0] rd1 [2];
  logic [15:0] ma [2];
  logic        en [2];
  logic        we [2];
  logic [31:0] wd [2];
  logic [31:0] mrd [2];
  logic        busy [2];
  logic [1:0]  dbg [2];

  bit [31:0] rmem [2][65536];   // memory seen by each DUT
  bit [31:0] mmem [2][65536];   // expected memory image held by the model

  int m_last [2];
  int m_w0 [2];
  int m_w1 [2];
  int m_own [2];
  logic [32:0] exp_q0[$];       // {client id, expected read data}
  logic [32:0] exp_q1[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(16), .DW(32), .PRIO_RR(1), .MAX_WAIT(15)) u_rr (
    .clk(clk), .reset(reset),
    .c0_req(c0_req), .c1_req(c1_req), .c0_we(c0_we), .c1_we(c1_we),
    .c0_lock(c0_lock), .c1_lock(c1_lock), .c0_addr(c0_addr), .c1_addr(c1_addr),
    .c0_wdata(c0_wdata), .c1_wdata(c1_wdata),
    .c0_gnt(g0[0]), .c1_gnt(g1[0]), .c0_rvalid(rv0[0]), .c1_rvalid(rv1[0]),
    .c0_rdata(rd0[0]), .c1_rdata(rd1[0]),
    .mem_addr(ma[0]), .mem_en(en[0]), .mem_we(we[0]), .mem_wdata(wd[0]),
    .mem_rdata(mrd[0]), .busy(busy[0]), .owner_dbg(dbg[0])
  );

  mem_port_arbiter #(.AW(16), .DW(32), .PRIO_RR(0), .MAX_WAIT(3)) u_fx (
    .clk(clk), .reset(reset),
    .c0_req(c0_req), .c1_req(c1_req), .c0_we(c0_we), .c1_we(c1_we),
    .c0_lock(c0_lock), .c1_lock(c1_lock), .c0_addr(c0_addr), .c1_addr(c1_addr),
    .c0_wdata(c0_wdata), .c1_wdata(c1_wdata),
    .c0_gnt(g0[1]), .c1_gnt(g1[1]), .c0_rvalid(rv0[1]), .c1_rvalid(rv1[1]),
    .c0_rdata(rd0[1]), .c1_rdata(rd1[1]),
    .mem_addr(ma[1]), .mem_en(en[1]), .mem_we(we[1]), .mem_wdata(wd[1]),
    .mem_rdata(mrd[1]), .busy(busy[1]), .owner_dbg(dbg[1])
  );

  // Synchronous memories with one-cycle read latency, one per DUT.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (en[k]) begin
        if (we[k]) rmem[k][ma[k]] <= wd[k];
        else       mrd[k] <= rmem[k][ma[k]];
      end
    end
  end

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[inst %0d] t=%0t: got %h, expected %h", name, k, $time, act, exp);
    end
  endtask

  // Rule-level model: decides the winner from the arbitration rules and checks
  // every output of instance k for the current cycle, then advances history.
  task automatic model_cycle(input int k);
    int          win;
    int          maxw;
    bit          rr;
    bit          ret;
    logic [32:0] e;
    logic        wr;
    logic [15:0] a;
    logic [31:0] d;
    rr   = (k == 0);
    maxw = rr ? 15 : 3;
    e    = '0;
    if (reset) begin
      chk("rst_gnt0", k, 32'(g0[k]), 0);
      chk("rst_gnt1", k, 32'(g1[k]), 0);
      chk("rst_mem_en", k, 32'(en[k]), 0);
      chk("rst_mem_we", k, 32'(we[k]), 0);
      chk("rst_mem_addr", k, 32'(ma[k]), 0);
      chk("rst_mem_wdata", k, wd[k], 0);
      chk("rst_rvalid0", k, 32'(rv0[k]), 0);
      chk("rst_rvalid1", k, 32'(rv1[k]), 0);
      chk("rst_busy", k, 32'(busy[k]), 0);
      m_last[k] = 1;
      m_w0[k]   = 0;
      m_w1[k]   = 0;
      m_own[k]  = -1;
      if (k == 0) exp_q0.delete();
      else        exp_q1.delete();
      return;
    end
    ret = 1'b0;
    if (k == 0 && exp_q0.size() > 0) begin e = exp_q0.pop_front(); ret = 1'b1; end
    else if (k == 1 && exp_q1.size() > 0) begin e = exp_q1.pop_front(); ret = 1'b1; end
    chk("rvalid0", k, 32'(rv0[k]), 32'(ret && !e[32]));
    chk("rvalid1", k, 32'(rv1[k]), 32'(ret && e[32]));
    if (ret) chk("rdata", k, e[32] ? rd1[k] : rd0[k], e[31:0]);

    win = -1;
    if (m_own[k] == 0 && c0_req)      win = 0;
    else if (m_own[k] == 1 && c1_req) win = 1;
    else if (c0_req && c1_req)        win = rr ? ((m_last[k] == 1) ? 0 : 1) : ((m_w1[k] >= maxw) ? 1 : 0);
    else if (c0_req)                  win = 0;
    else if (c1_req)                  win = 1;

    wr = (win == 0) ? c0_we    : (win == 1) ? c1_we    : 1'b0;
    a  = (win == 0) ? c0_addr  : (win == 1) ? c1_addr  : 16'h0;
    d  = (win == 0) ? c0_wdata : (win == 1) ? c1_wdata : 32'h0;
    chk("gnt0", k, 32'(g0[k]), 32'(win == 0));
    chk("gnt1", k, 32'(g1[k]), 32'(win == 1));
    chk("mem_en", k, 32'(en[k]), 32'(win >= 0));
    chk("mem_we", k, 32'(we[k]), 32'(wr));
    chk("mem_addr", k, 32'(ma[k]), 32'(a));
    chk("mem_wdata", k, wd[k], d);
    chk("busy", k, 32'(busy[k]), 32'(win >= 0 || ret));

    if (win >= 0) begin
      if (wr) mmem[k][a] = d;
      else if (k == 0) exp_q0.push_back({win == 1, mmem[k][a]});
      else             exp_q1.push_back({win == 1, mmem[k][a]});
      m_last[k] = win;
    end
    m_w0[k]  = (c0_req && win != 0) ? ((m_w0[k] < 15) ? m_w0[k] + 1 : 15) : 0;
    m_w1[k]  = (c1_req && win != 1) ? ((m_w1[k] < 15) ? m_w1[k] + 1 : 15) : 0;
    m_own[k] = (win == 0 && c0_lock) ? 0 : (win == 1 && c1_lock) ? 1 : -1;
  endtask

  // Compare process: every cycle, both instances, away from the active edge.
  always @(negedge clk) begin
    model_cycle(0);
    model_cycle(1);
  end

  task automatic set_c0(input bit req, input bit w, input bit lock, input logic [15:0] a, input logic [31:0] d);
    c0_req = req; c0_we = w; c0_lock = lock; c0_addr = a; c0_wdata = d;
  endtask

  task automatic set_c1(input bit req, input bit w, input bit lock, input logic [15:0] a, input logic [31:0] d);
    c1_req = req; c1_we = w; c1_lock = lock; c1_addr = a; c1_wdata = d;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] rr_pat;
  logic [7:0] fx_pat;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      rmem[0][i] = 32'hA500_0000 ^ i;
      rmem[1][i] = 32'hA500_0000 ^ i;
      mmem[0][i] = 32'hA500_0000 ^ i;
      mmem[1][i] = 32'hA500_0000 ^ i;
    end
    for (int k = 0; k < 2; k++) begin
      rmem[k][16'h0010] = 32'hAABB_CCDD;
      mmem[k][16'h0010] = 32'hAABB_CCDD;
    end

    // Reset held with both clients requesting: everything quiet.
    reset = 1'b1;
    set_c0(1, 0, 0, 16'h0010, 32'h0);
    set_c1(1, 0, 0, 16'h0020, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("hand_rst_g0", 0, 32'(g0[0]), 0);
      chk("hand_rst_g1", 1, 32'(g1[1]), 0);
      chk("hand_rst_busy", 0, 32'(busy[0]), 0);
      nxt();
    end
    reset = 1'b0;
    set_c0(0, 0, 0, 16'h0, 32'h0);
    set_c1(0, 0, 0, 16'h0, 32'h0);

    // Idle.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("hand_idle_en", 0, 32'(en[0]), 0);
      chk("hand_idle_addr", 0, 32'(ma[0]), 0);
      chk("hand_idle_busy", 0, 32'(busy[0]), 0);
      nxt();
    end

    // Continuous tie: RR alternates from c0, fixed gives c1 every 4th cycle.
    rr_pat = 8'b0101_0101;
    fx_pat = 8'b0111_0111;
    for (int i = 0; i < 8; i++) begin
      set_c0(1, 0, 0, 16'(32'h0020 + i), 32'h0);
      set_c1(1, 0, 0, 16'(32'h0040 + i), 32'h0);
      @(negedge clk);
      chk("hand_rr_tie_g0", 0, 32'(g0[0]), 32'(rr_pat[i]));
      chk("hand_rr_tie_g1", 0, 32'(g1[0]), 32'(!rr_pat[i]));
      chk("hand_fx_starve_g0", 1, 32'(g0[1]), 32'(fx_pat[i]));
      chk("hand_fx_starve_g1", 1, 32'(g1[1]), 32'(!fx_pat[i]));
      nxt();
    end
    set_c0(0, 0, 0, 16'h0, 32'h0);
    set_c1(0, 0, 0, 16'h0, 32'h0);
    @(negedge clk);
    nxt();

    // Single read at 0x0010.
    set_c0(1, 0, 0, 16'h0010, 32'h0);
    @(negedge clk);
    chk("hand_sr_gnt", 0, 32'(g0[0]), 1);
    chk("hand_sr_en", 0, 32'(en[0]), 1);
    chk("hand_sr_addr", 0, 32'(ma[0]), 32'h0010);
    nxt();
    set_c0(0, 0, 0, 16'h0, 32'h0);
    @(negedge clk);
    chk("hand_sr_rvalid", 0, 32'(rv0[0]), 1);
    chk("hand_sr_rdata", 0, rd0[0], 32'hAABB_CCDD);
    chk("hand_sr_rvalid1", 0, 32'(rv1[0]), 0);
    nxt();

    // Locked write burst from c1 while c0 keeps requesting a read.
    for (int i = 0; i < 5; i++) begin
      set_c0(1, 0, 0, 16'h6301, 32'h0);
      set_c1(i < 4, 1, i < 3, 16'(32'h6300 + i), 32'h1000_0000 + i);
      @(negedge clk);
      chk("hand_lock_g1", 0, 32'(g1[0]), 32'(i < 4));
      chk("hand_lock_g0", 0, 32'(g0[0]), 32'(i == 4));
      nxt();
    end
    set_c0(0, 0, 0, 16'h0, 32'h0);
    set_c1(0, 0, 0, 16'h0, 32'h0);
    @(negedge clk);
    chk("hand_lock_rvalid", 0, 32'(rv0[0]), 1);
    chk("hand_lock_rdata", 0, rd0[0], 32'h1000_0001);
    nxt();

    // c0 takes ownership, keeps it against a tie, then drops req and c1 wins.
    set_c0(1, 0, 1, 16'h0050, 32'h0);
    @(negedge clk);
    chk("hand_own_take", 0, 32'(g0[0]), 1);
    nxt();
    set_c1(1, 0, 0, 16'h0060, 32'h0);
    @(negedge clk);
    chk("hand_own_hold_rr", 0, 32'(g0[0]), 1);
    chk("hand_own_hold_fx", 1, 32'(g0[1]), 1);
    chk("hand_own_block", 0, 32'(g1[0]), 0);
    nxt();
    set_c0(0, 0, 0, 16'h0, 32'h0);
    @(negedge clk);
    chk("hand_own_drop_rr", 0, 32'(g1[0]), 1);
    chk("hand_own_drop_fx", 1, 32'(g1[1]), 1);
    nxt();
    set_c1(0, 0, 0, 16'h0, 32'h0);
    @(negedge clk);
    nxt();

    // Reset right after a granted read drops the return.
    set_c0(1, 0, 0, 16'h0010, 32'h0);
    @(negedge clk);
    chk("hand_mid_gnt", 0, 32'(g0[0]), 1);
    nxt();
    reset = 1'b1;
    set_c0(0, 0, 0, 16'h0, 32'h0);
    @(negedge clk);
    chk("hand_mid_rvalid", 0, 32'(rv0[0]), 0);
    chk("hand_mid_busy", 0, 32'(busy[0]), 0);
    nxt();
    reset = 1'b0;
    set_c0(1, 0, 0, 16'h0070, 32'h0);
    set_c1(1, 0, 0, 16'h0080, 32'h0);
    @(negedge clk);
    chk("hand_post_rst_rr", 0, 32'(g0[0]), 1);
    chk("hand_post_rst_fx", 1, 32'(g0[1]), 1);
    nxt();
    set_c0(0, 0, 0, 16'h0, 32'h0);
    set_c1(0, 0, 0, 16'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      nxt();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-client arbiter for the single-port 32-bit image memory (16-bit word address, 1-cycle synchronous read latency). It lets the Sobel accelerator and a second requester share one memory port, such as the image loader/DMA or a second accelerator instance. Each cycle it grants at most one transaction, routes read data back to the requester one cycle later, and supports bus locking for back-to-back bursts. Clients must tolerate `gnt=0` stalls.

## Interface
Parameters:
- `AW`, 16: address width (words).
- `DW`, 32: data width.
- `PRIO_RR`, 1: 1 = round-robin, 0 = fixed priority with client 0 preferred.
- `MAX_WAIT`, 15: starvation limit in cycles for fixed mode; range 1..15.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `c0_req`, `c1_req`  in  1  transaction request; held until granted.
- `c0_we`, `c1_we`  in  1  1 = write, 0 = read.
- `c0_lock`, `c1_lock`  in  1  request to keep ownership after this grant.
- `c0_addr`, `c1_addr`  in  AW  word address.
- `c0_wdata`, `c1_wdata`  in  DW  write data.
- `c0_gnt`, `c1_gnt`  out  1  transaction accepted this cycle (combinational).
- `c0_rvalid`, `c1_rvalid`  out  1  read data valid for that client this cycle.
- `c0_rdata`, `c1_rdata`  out  DW  read data; both are wired to `mem_rdata`.
- `mem_addr`  out  AW  memory address.
- `mem_en`  out  1  memory enable.
- `mem_we`  out  1  memory write enable.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data, valid 1 cycle after a read.
- `busy`  out  1  `mem_en` or a read return pending.

## Operation
State machine `owner` has three states:
- **FREE**: normal arbitration.
- **OWN0**: client 0 has exclusive ownership.
- **OWN1**: client 1 has exclusive ownership.

Arbitration in FREE:
- Only one requester: it wins.
- Both requesting, `PRIO_RR=1`: the client not granted most recently wins. The last-grant register updates on every grant.
- Both requesting, `PRIO_RR=0`: client 0 wins, unless `wait1 >= MAX_WAIT`, in which case client 1 wins.

Ownership (OWNx):
- Only client x can be granted. It is granted whenever `cx_req=1`.
- The other client waits, and its wait counter increments.
- Exit to FREE when the owner samples `lock=0` on a granted cycle, or when `cx_req=0`.
- Lock overrides the starvation rule.

Lock entry:
- A grant with `cx_lock=1` moves FREE→OWNx from the next cycle.

Granted cycle:
- `mem_en=1`.
- `mem_we`, `mem_addr` and `mem_wdata` are taken from the winner.

No grant:
- `mem_en=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`.

Read return:
- A registered tag (valid, id) is captured on a granted read.
- Next cycle, `c<id>_rvalid=1`.
- Writes never raise `rvalid`.

Wait counters `wait0` and `wait1`:
- 4-bit, saturating at 15.
- Increment when `req & !gnt`.
- Clear when granted or when `req=0`.

Reset values:
- `owner` = FREE.
- Last-grant = client 1, so client 0 wins the first round-robin tie.
- Wait counters = 0.
- Read tag cleared.

During reset:
- All `gnt`, `rvalid`, `mem_en` and `mem_we` are 0.
- `mem_addr` and `mem_wdata` are 0.
- `busy` is 0.

Reset mid-transaction:
- A pending `rvalid` is dropped.
- `owner` returns to FREE.

## Timing
- Grant is combinational from `req` and state. Memory signals are valid in the same cycle as `gnt`.
- Read latency is request grant cycle N → `rvalid`/`rdata` in cycle N+1.
- Read returns can overlap a new grant in N+1, so full throughput is 1 transaction per cycle.
- Write completes in the grant cycle.
- Simultaneous requests resolve in the same cycle. Exactly one `gnt` is high at a time.
- The owner may drop `req` for one cycle. Ownership is then released, and the other client may be granted in that same cycle.
- In fixed mode, maximum wait for client 1 is `MAX_WAIT+1` cycles, excluding lock periods.

## Test plan
- **Single read:** reset, then `c0_req=1`, `we=0`, `addr=0x0010`, memory returns 0xAABBCCDD → `c0_gnt=1` and `mem_en=1`/`mem_addr=0x0010` in cycle 0; `c0_rvalid=1`, `c0_rdata=0xAABBCCDD` in cycle 1; `c1_rvalid=0`.
- **Round-robin tie:** both clients request reads continuously → grants alternate c0,c1,c0,c1. Each `rvalid` goes to the matching client one cycle after its grant.
- **Fixed priority starvation:** `PRIO_RR=0`, `MAX_WAIT=3`, both request continuously → c0,c0,c0,c1,c0,c0,c0,c1… (client 1 wins on the cycle its wait counter reads 3).
- **Lock burst:** c1 writes 4 words at 0x6300–0x6303 with `lock=1` on the first 3 grants, while c0 requests throughout → four consecutive c1 grants, then c0 is granted in the fifth cycle.
- **Idle/reset behaviour:** no requests → `mem_en=0`, `mem_addr=0`, `busy=0`. Assert `reset` in the cycle after a granted c0 read → `c0_rvalid` stays 0. After reset release, a c0/c1 tie grants c0.
